// File: rtl/bit_stuff_gen_if.sv
// Serial stream and control bundle for bit_stuff_gen: upstream bit stream,
// downstream bit stream and packet-level control/status.
interface bit_stuff_gen_if;
  logic start;
  logic mode;
  logic in_bit;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic done;
  logic stuff_err;
  logic busy;

  modport master (
    output start, mode, in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_bit, out_valid, out_last, done, stuff_err, busy
  );

  modport slave (
    input  start, mode, in_bit, in_valid, in_last, out_ready,
    output in_ready, out_bit, out_valid, out_last, done, stuff_err, busy
  );
endinterface

// File: rtl/bit_stuff_gen.sv
// USB serial bit stuffer (mode 0) / unstuffer (mode 1) with an unprotected
// packet prefix and valid/ready streams on both sides.
module bit_stuff_gen #(
  parameter int RUN_LEN   = 6,
  parameter int SKIP_BITS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bit_stuff_gen_if.slave bus
);

  localparam int SP_W   = (SKIP_BITS < 1) ? 1 : $clog2(SKIP_BITS + 1);
  localparam int ONES_W = $clog2(RUN_LEN + 1);
  localparam logic [SP_W-1:0]   SP_MAX    = SP_W'(SKIP_BITS);
  localparam logic [SP_W-1:0]   SP_LAST   = SP_W'((SKIP_BITS > 0) ? (SKIP_BITS - 1) : 0);
  localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(RUN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STUFF = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic                mode_r, mode_s;
  logic                pend_last_r, pend_last_s;
  logic [SP_W-1:0]     sp_r, sp_s;
  logic [ONES_W-1:0]   ones_r, ones_s;

  logic in_ready_s;
  logic out_bit_s;
  logic out_valid_s;
  logic out_last_s;
  logic done_s;
  logic stuff_err_s;
  logic it_pass_s;

  // Input transfer in the pass-through states, where in_ready follows out_ready.
  assign it_pass_s = bus.in_valid & bus.out_ready;

  // Next-state, counter updates and combinational stream outputs.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    pend_last_s = pend_last_r;
    sp_s        = sp_r;
    ones_s      = ones_r;
    in_ready_s  = 1'b0;
    out_bit_s   = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    done_s      = 1'b0;
    stuff_err_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          mode_s      = bus.mode;
          sp_s        = '0;
          ones_s      = '0;
          pend_last_s = 1'b0;
          state_s     = (SKIP_BITS == 0) ? ST_RUN : ST_PASS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PASS: begin
        out_bit_s   = bus.in_bit;
        out_valid_s = bus.in_valid;
        out_last_s  = bus.in_last;
        in_ready_s  = bus.out_ready;
        if (it_pass_s) begin
          if (sp_r != SP_MAX) begin
            sp_s = sp_r + 1'b1;
          end else begin
            sp_s = sp_r;
          end
          if (bus.in_last) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else if (sp_r == SP_LAST) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PASS;
          end
        end else begin
          state_s = ST_PASS;
        end
      end

      ST_RUN: begin
        out_bit_s   = bus.in_bit;
        out_valid_s = bus.in_valid;
        out_last_s  = bus.in_last;
        in_ready_s  = bus.out_ready;
        if (it_pass_s) begin
          if (bus.in_bit && (ones_r == ONES_LAST)) begin
            // Run complete: the stuff slot follows this bit, even when it is the last one.
            ones_s      = '0;
            pend_last_s = bus.in_last;
            state_s     = ST_STUFF;
          end else begin
            if (bus.in_bit) begin
              ones_s = ones_r + 1'b1;
            end else begin
              ones_s = '0;
            end
            if (bus.in_last) begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RUN;
            end
          end
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_STUFF: begin
        if (!mode_r) begin
          out_bit_s   = 1'b0;
          out_valid_s = 1'b1;
          out_last_s  = pend_last_r;
          if (bus.out_ready) begin
            if (pend_last_r) begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_STUFF;
          end
        end else if (pend_last_r) begin
          // Packet ended on the run itself; no stuff bit will arrive.
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          in_ready_s = 1'b1;
          if (bus.in_valid) begin
            if (!bus.in_bit) begin
              state_s = bus.in_last ? ST_IDLE : ST_RUN;
              done_s  = bus.in_last;
            end else begin
              stuff_err_s = 1'b1;
              state_s     = bus.in_last ? ST_IDLE : ST_ERR;
              done_s      = bus.in_last;
            end
          end else begin
            state_s = ST_STUFF;
          end
        end
      end

      ST_ERR: begin
        in_ready_s = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERR;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      pend_last_r <= 1'b0;
      sp_r        <= '0;
      ones_r      <= '0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      pend_last_r <= pend_last_s;
      sp_r        <= sp_s;
      ones_r      <= ones_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_bit   = out_bit_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_last  = out_last_s;
  assign bus.done      = done_s;
  assign bus.stuff_err = stuff_err_s;
  assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: doc/bit_stuff_gen.md
# bit_stuff_gen

Parametrised serial bit stuffer/unstuffer for the USB serial path, successor to the fixed stuff-only block. Sits between packet serialiser and NRZI encoder on transmit (stuff mode), and between NRZI decoder and packet deserialiser on receive (unstuff mode). Run length and the unprotected prefix length are parameters, and both sides use valid/ready handshakes instead of a pause strobe. Unstuff mode detects stuff errors.

## Interface
- RUN_LEN, default 6: consecutive ones that trigger a stuffed zero; legal range 1..15.
- SKIP_BITS, default 16: leading bits of each packet passed through with no run counting and no stuffing; 0 is legal.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle packet start; honoured only in IDLE.
- mode  in  1  0 = stuff, 1 = unstuff; sampled with start and held internally for the packet.
- in_bit  in  1  serial data in.
- in_valid  in  1  in_bit valid.
- in_last  in  1  qualifies the final input bit of the packet.
- in_ready  out  1  block accepts in_bit this cycle.
- out_bit  out  1  serial data out.
- out_valid  out  1  out_bit valid.
- out_last  out  1  qualifies the final output bit.
- out_ready  in  1  downstream accepts out_bit.
- done  out  1  one-cycle pulse when the packet completes.
- stuff_err  out  1  one-cycle pulse on an unstuff violation.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Input transfer (IT): in_valid & in_ready. Output transfer (OT): out_valid & out_ready.
- Counters: sp counts 0..SKIP_BITS, width $clog2(SKIP_BITS+1), minimum 1. ones counts 0..RUN_LEN, width $clog2(RUN_LEN+1). Both are cleared on start. Neither counter wraps.
- In PASS and RUN, data flows combinationally: out_bit = in_bit, out_valid = in_valid, out_last = in_last, in_ready = out_ready.
- States:
  - IDLE: in_ready = 0, out_valid = 0. On start, latch mode and go to PASS, or to RUN if SKIP_BITS == 0.
  - PASS: each IT increments sp. An IT with sp == SKIP_BITS-1 moves to RUN. An IT with in_last pulses done and returns to IDLE; in_last takes priority.
  - RUN: on each IT, a 1 increments ones and a 0 clears it. An IT carrying a 1 with ones == RUN_LEN-1 clears ones and goes to STUFF, latching pending_last = in_last. Any other IT with in_last pulses done and returns to IDLE.
  - STUFF, mode 0: out_bit = 0, out_valid = 1, out_last = pending_last, in_ready = 0. On OT, if pending_last, pulse done and go to IDLE; otherwise go to RUN.
  - STUFF, mode 1: out_valid = 0, in_ready = 1, and the stuffed bit is discarded. An IT carrying a 0 goes to RUN, or pulses done and goes to IDLE if in_last. An IT carrying a 1 pulses stuff_err and goes to ERR; if that bit also has in_last, it additionally pulses done and goes to IDLE. If pending_last is set in mode 1, pulse done and go to IDLE on the next cycle without consuming input.
  - ERR: in_ready = 1, out_valid = 0. Input is dropped until an IT with in_last, which pulses done and goes to IDLE.
- Unstuff end of packet: when in_last lands on a discarded stuff bit, the consumer sees no out_last. done is the authoritative end-of-packet marker in both modes.
- start outside IDLE is ignored. mode changes mid-packet are ignored.
- Reset mid-packet returns to IDLE immediately. All in-flight bits are lost and no done is pulsed.

## Timing
- Reset values: state IDLE, sp = 0, ones = 0, pending_last = 0. Outputs out_bit, out_valid, out_last, in_ready, done, stuff_err and busy are all 0. out_bit is never high-impedance.
- Data latency is 0 cycles (combinational in_bit to out_bit path in PASS and RUN). Outputs can therefore depend combinationally on in_* and out_ready.
- start to first possible IT: 1 cycle.
- A stuffed zero costs exactly one extra cycle when out_ready is high. A stuffed-bit discard costs one input cycle.
- done and stuff_err are registered? No: both are combinational one-cycle pulses in the cycle of the qualifying transfer.
- busy falls the cycle after done.
- With out_ready low in STUFF, out_bit = 0 and out_valid = 1 are held stable until accepted.

## Test plan
- Stuff, SKIP_BITS=16, 16 ones then 0101 with in_last on the final bit -> 20 output bits identical to input, no stuffing, done with the last OT.
- Stuff, SKIP_BITS=0, input 1111111 0 (in_last on the 0) -> output 111111 0 1 0 (9 bits); the inserted 0 follows the sixth 1, and in_ready is low for exactly that cycle.
- Stuff, the packet ends on the sixth consecutive 1 (in_last) -> extra output 0 with out_last = 1, done on its OT.
- Unstuff, SKIP_BITS=0, input 111111 0 1 (last) -> output 1111111 (7 bits), no stuff_err, done.
- Unstuff, input 1111111 followed by 3 more bits, last on the tenth -> stuff_err pulse on the seventh bit, outputs stop after 6 bits, done on the tenth.
- Backpressure: out_ready low for 3 cycles during STUFF -> out_bit = 0 is held and not duplicated. Separately, rst_n low mid-packet -> busy = 0 immediately and the next start is handled normally.
